// File: rtl/uart_command_sequencer_pkg.sv
// Shared command codes, operand addresses and sequencer state encoding.
package uart_command_sequencer_pkg;

   localparam logic [7:0] CMD_WRITE   = 8'hAA;
   localparam logic [7:0] CMD_READ    = 8'hBB;
   localparam logic [7:0] CMD_ALU_OPS = 8'hCC;
   localparam logic [7:0] CMD_ALU     = 8'hDD;

   localparam int unsigned OPERAND_A_ADDR = 0;
   localparam int unsigned OPERAND_B_ADDR = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_RD_ADDR,
      ST_WAIT_READ,
      ST_OP_A,
      ST_OP_B,
      ST_ALU_FUNC,
      ST_WAIT_ALU
   } seq_state_e;

endpackage

// File: rtl/uart_command_sequencer_timer.sv
// Inter-byte / response watchdog: counts cycles while run is high, expires at TIMEOUT_CYCLES-1.
module inter_byte_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   assign expired = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

   // Cycle counter; cleared by any byte or while idle, holds once expired.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || !run) begin
         count <= '0;
      end else if (!expired) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_command_sequencer.sv
// Parses UART command frames and sequences register-file and ALU strobes.
module uart_command_sequencer
   import uart_command_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = 8,
   parameter int unsigned ADDRESS_WIDTH      = 4,
   parameter int unsigned ALU_FUNCTION_WIDTH = 4,
   parameter int unsigned TIMEOUT_CYCLES     = 1000000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_WIDTH-1:0]         receiver_parallel_data,
   input  logic                          receiver_parallel_data_valid,
   input  logic                          transmitter_path_free,
   input  logic                          read_data_valid,
   input  logic                          ALU_result_valid,
   output logic [ADDRESS_WIDTH-1:0]      address,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic                          write_enable,
   output logic                          read_enable,
   output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
   output logic                          ALU_enable,
   output logic                          ALU_clk_enable,
   output logic                          command_error,
   output logic                          frame_timeout
);

   seq_state_e                    state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]      address_d;
   logic [DATA_WIDTH-1:0]         write_data_d;
   logic [ALU_FUNCTION_WIDTH-1:0] func_d;
   logic                          we_d, re_d, alu_en_d, clk_en_d, err_d, to_d;
   logic                          expired_c, addr_ok_c, resp_done_c;
   logic [DATA_WIDTH-1:0]         byte_c;
   logic                          vld_c;

   assign byte_c      = receiver_parallel_data;
   assign vld_c       = receiver_parallel_data_valid;
   assign addr_ok_c   = (byte_c >> ADDRESS_WIDTH) == '0;
   assign resp_done_c = ((state_q == ST_WAIT_READ) && read_data_valid) ||
                        ((state_q == ST_WAIT_ALU)  && ALU_result_valid);

   inter_byte_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (vld_c),
      .run     (state_q != ST_IDLE),
      .expired (expired_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         address        <= '0;
         write_data     <= '0;
         ALU_function   <= '0;
         write_enable   <= 1'b0;
         read_enable    <= 1'b0;
         ALU_enable     <= 1'b0;
         ALU_clk_enable <= 1'b0;
         command_error  <= 1'b0;
         frame_timeout  <= 1'b0;
      end else begin
         state_q        <= state_d;
         address        <= address_d;
         write_data     <= write_data_d;
         ALU_function   <= func_d;
         write_enable   <= we_d;
         read_enable    <= re_d;
         ALU_enable     <= alu_en_d;
         ALU_clk_enable <= clk_en_d;
         command_error  <= err_d;
         frame_timeout  <= to_d;
      end
   end

   // Frame parsing, strobe generation, rejection and timeout.
   always_comb begin
      state_d      = state_q;
      address_d    = address;
      write_data_d = write_data;
      func_d       = ALU_function;
      we_d         = 1'b0;
      re_d         = 1'b0;
      alu_en_d     = 1'b0;
      err_d        = 1'b0;
      to_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (vld_c) begin
               if (!transmitter_path_free) begin
                  err_d = 1'b1;
               end else if (byte_c == DATA_WIDTH'(CMD_WRITE)) begin
                  state_d = ST_WR_ADDR;
               end else if (byte_c == DATA_WIDTH'(CMD_READ)) begin
                  state_d = ST_RD_ADDR;
               end else if (byte_c == DATA_WIDTH'(CMD_ALU_OPS)) begin
                  state_d = ST_OP_A;
               end else if (byte_c == DATA_WIDTH'(CMD_ALU)) begin
                  state_d = ST_ALU_FUNC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WR_ADDR, ST_RD_ADDR: begin
            if (vld_c) begin
               if (!addr_ok_c) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  address_d = byte_c[ADDRESS_WIDTH-1:0];
                  if (state_q == ST_WR_ADDR) begin
                     state_d = ST_WR_DATA;
                  end else begin
                     re_d    = 1'b1;
                     state_d = ST_WAIT_READ;
                  end
               end
            end
         end
         ST_WR_DATA: begin
            if (vld_c) begin
               write_data_d = byte_c;
               we_d         = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         ST_OP_A, ST_OP_B: begin
            if (vld_c) begin
               write_data_d = byte_c;
               we_d         = 1'b1;
               if (state_q == ST_OP_A) begin
                  address_d = ADDRESS_WIDTH'(OPERAND_A_ADDR);
                  state_d   = ST_OP_B;
               end else begin
                  address_d = ADDRESS_WIDTH'(OPERAND_B_ADDR);
                  state_d   = ST_ALU_FUNC;
               end
            end
         end
         ST_ALU_FUNC: begin
            if (vld_c) begin
               func_d   = byte_c[ALU_FUNCTION_WIDTH-1:0];
               alu_en_d = 1'b1;
               state_d  = ST_WAIT_ALU;
            end
         end
         ST_WAIT_READ, ST_WAIT_ALU: begin
            if (vld_c) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (resp_done_c) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bytes and responses take priority over an expiring timer.
      if ((state_q != ST_IDLE) && !vld_c && !resp_done_c && expired_c) begin
         to_d    = 1'b1;
         state_d = ST_IDLE;
      end

      clk_en_d = (state_d == ST_OP_A) || (state_d == ST_OP_B) ||
                 (state_d == ST_ALU_FUNC) || (state_d == ST_WAIT_ALU);
   end

endmodule

// File: tb/tb_uart_command_sequencer.sv
// Directed bench for uart_command_sequencer with a short timeout.
module tb_uart_command_sequencer;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned FW = 4;
   localparam int unsigned TO = 100;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          path_free = 1'b1;
   logic          rd_valid = 1'b0;
   logic          alu_valid = 1'b0;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic          write_enable, read_enable, ALU_enable, ALU_clk_enable;
   logic [FW-1:0] ALU_function;
   logic          command_error, frame_timeout;

   int total = 0;
   int bad   = 0;
   int n_we  = 0;
   int n_err = 0;
   int n_to  = 0;
   int base_we, base_err, base_to;

   uart_command_sequencer #(
      .DATA_WIDTH         (DW),
      .ADDRESS_WIDTH      (AW),
      .ALU_FUNCTION_WIDTH (FW),
      .TIMEOUT_CYCLES     (TO)
   ) dut (
      .clk                          (clk),
      .reset                        (reset),
      .receiver_parallel_data       (rx_data),
      .receiver_parallel_data_valid (rx_valid),
      .transmitter_path_free        (path_free),
      .read_data_valid              (rd_valid),
      .ALU_result_valid             (alu_valid),
      .address                      (address),
      .write_data                   (write_data),
      .write_enable                 (write_enable),
      .read_enable                  (read_enable),
      .ALU_function                 (ALU_function),
      .ALU_enable                   (ALU_enable),
      .ALU_clk_enable               (ALU_clk_enable),
      .command_error                (command_error),
      .frame_timeout                (frame_timeout)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (write_enable)  n_we  <= n_we + 1;
      if (command_error) n_err <= n_err + 1;
      if (frame_timeout) n_to  <= n_to + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one byte for one cycle; returns 1 time unit after the sampling edge.
   task automatic send_byte(input logic [DW-1:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst address", 32'(address), 32'h0);
      check("rst strobes", 32'({write_enable, read_enable, ALU_enable, ALU_clk_enable,
                                command_error, frame_timeout}), 32'h0);
      #22 reset = 1'b1;
      @(posedge clk); #1;

      // 1: register write
      base_we = n_we; base_err = n_err;
      send_byte(8'hAA);
      check("t1 we after cmd", 32'(write_enable), 32'h0);
      send_byte(8'h05);
      send_byte(8'h3C);
      check("t1 we", 32'(write_enable), 32'h1);
      check("t1 addr", 32'(address), 32'h5);
      check("t1 wdata", 32'(write_data), 32'h3C);
      tick(1);
      check("t1 we single", 32'(n_we - base_we), 32'h1);
      check("t1 no err", 32'(n_err - base_err), 32'h0);

      // 2: register read, response, then back-to-back write
      send_byte(8'hBB);
      send_byte(8'h07);
      check("t2 re", 32'(read_enable), 32'h1);
      check("t2 addr", 32'(address), 32'h7);
      tick(10);
      rd_valid = 1'b1; tick(1); rd_valid = 1'b0;
      send_byte(8'hAA);
      send_byte(8'h02);
      send_byte(8'h55);
      check("t2 next we", 32'(write_enable), 32'h1);
      check("t2 next addr", 32'(address), 32'h2);
      check("t2 next wdata", 32'(write_data), 32'h55);

      // byte arriving in WAIT_READ is rejected
      send_byte(8'hBB);
      send_byte(8'h06);
      send_byte(8'h33);
      check("wait_read byte err", 32'(command_error), 32'h1);

      // 3: ALU op with operands
      send_byte(8'hCC);
      check("t3 clk_en on cmd", 32'(ALU_clk_enable), 32'h1);
      check("t3 alu_en not yet", 32'(ALU_enable), 32'h0);
      send_byte(8'h12);
      check("t3 op a", 32'({write_enable, address, write_data}), 32'h1012);
      send_byte(8'h34);
      check("t3 op b", 32'({write_enable, address, write_data}), 32'h1134);
      send_byte(8'h02);
      check("t3 alu_en", 32'(ALU_enable), 32'h1);
      check("t3 func", 32'(ALU_function), 32'h2);
      tick(3);
      alu_valid = 1'b1;
      check("t3 clk_en before result", 32'(ALU_clk_enable), 32'h1);
      tick(1); alu_valid = 1'b0;
      check("t3 clk_en after result", 32'(ALU_clk_enable), 32'h0);

      // 4: timeout 100 cycles after the last accepted byte's sampling edge
      base_we = n_we; base_to = n_to;
      send_byte(8'hAA);
      send_byte(8'h05);
      tick(TO - 1);
      check("t4 no timeout yet", 32'(frame_timeout), 32'h0);
      tick(1);
      check("t4 timeout", 32'(frame_timeout), 32'h1);
      tick(1);
      check("t4 timeout single", 32'(n_to - base_to), 32'h1);
      check("t4 no we", 32'(n_we - base_we), 32'h0);
      send_byte(8'hDD);
      check("t4 dd clk_en", 32'(ALU_clk_enable), 32'h1);
      send_byte(8'h01);
      check("t4 dd alu_en", 32'(ALU_enable), 32'h1);
      check("t4 dd func", 32'(ALU_function), 32'h1);
      alu_valid = 1'b1; tick(1); alu_valid = 1'b0;
      check("t4 dd clk_en off", 32'(ALU_clk_enable), 32'h0);

      // 5: rejected bytes
      base_we = n_we;
      send_byte(8'h5A);
      check("t5 unknown err", 32'(command_error), 32'h1);
      tick(1);
      check("t5 err single", 32'(command_error), 32'h0);
      path_free = 1'b0;
      send_byte(8'hBB);
      check("t5 busy err", 32'(command_error), 32'h1);
      path_free = 1'b1;
      send_byte(8'hAA);
      send_byte(8'h15);
      check("t5 addr range err", 32'(command_error), 32'h1);
      send_byte(8'hAA);
      send_byte(8'h03);
      send_byte(8'h77);
      check("t5 recovery we", 32'({write_enable, address, write_data}), 32'h1377);
      check("t5 we count", 32'(n_we - base_we), 32'h0);

      // 6: async reset during WAIT_ALU
      send_byte(8'hDD);
      send_byte(8'h04);
      check("t6 in wait_alu", 32'(ALU_clk_enable), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("t6 rst clk_en", 32'(ALU_clk_enable), 32'h0);
      check("t6 rst regs", 32'({address, write_data, ALU_function}), 32'h0);
      #4 reset = 1'b1;
      @(posedge clk); #1;
      base_err = n_err;
      alu_valid = 1'b1; tick(1); alu_valid = 1'b0;
      tick(1);
      check("t6 stray result", 32'({ALU_clk_enable, ALU_enable}), 32'h0);
      check("t6 stray no err", 32'(n_err - base_err), 32'h0);
      send_byte(8'hAA);
      send_byte(8'h09);
      send_byte(8'h11);
      check("t6 after reset we", 32'({write_enable, address, write_data}), 32'h1911);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
